// File: rtl/spi_fsm_if.sv
// spi_fsm_if: chip-select/strobe inputs and control outputs of the SPI transaction controller.
// abortCnt exists only when SPI_FSM_ABORT_CNT_EN is defined.
interface spi_fsm_if;
  logic cs;
  logic sclkPosEdge;
  logic rwBit;
  logic srParallelLoad;
  logic addrWE;
  logic dmWE;
  logic misoBufE;
`ifdef SPI_FSM_ABORT_CNT_EN
  logic [7:0] abortCnt;
  modport master (output cs, sclkPosEdge, rwBit, input srParallelLoad, addrWE, dmWE, misoBufE, abortCnt);
  modport slave (input cs, sclkPosEdge, rwBit, output srParallelLoad, addrWE, dmWE, misoBufE, abortCnt);
`else
  modport master (output cs, sclkPosEdge, rwBit, input srParallelLoad, addrWE, dmWE, misoBufE);
  modport slave (input cs, sclkPosEdge, rwBit, output srParallelLoad, addrWE, dmWE, misoBufE);
`endif
endinterface

// File: rtl/spi_fsm.sv
// spi_fsm: Moore transaction controller sequencing address, read and write phases of an SPI access.
// Optional saturating abort counter enabled by SPI_FSM_ABORT_CNT_EN.
module spi_fsm #(
  parameter int width    = 8,
  parameter int cntWidth = 4
) (
  input logic       clk,
  input logic       reset,
  spi_fsm_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GOT_ADDR, READ_WAIT, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_COMMIT, DONE
  } state_t;
  state_t r_state, w_next;
  logic [cntWidth-1:0] r_cnt, w_cnt, w_inc;
  logic w_full;
  assign w_inc  = r_cnt + 1'b1;
  assign w_full = bus.sclkPosEdge && w_inc == cntWidth'(width);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
  // Counter restarts at zero on every phase change, so it never reaches past width.
  always_comb begin
    w_next = r_state;
    w_cnt  = '0;
    case (r_state)
      IDLE:         w_next = bus.cs ? IDLE : GET_ADDR;
      GET_ADDR, READ_SEND, WRITE_RECV: begin
        w_cnt = bus.sclkPosEdge && !w_full ? w_inc : r_cnt;
        if (w_full)
          w_next = r_state == GET_ADDR ? GOT_ADDR : r_state == READ_SEND ? DONE : WRITE_COMMIT;
      end
      GOT_ADDR:     w_next = bus.rwBit ? READ_WAIT : WRITE_RECV;
      READ_WAIT:    w_next = READ_LOAD;
      READ_LOAD:    w_next = READ_SEND;
      WRITE_COMMIT: w_next = DONE;
      DONE:         w_next = DONE;
      default:      w_next = IDLE;
    endcase
    if (bus.cs && r_state != IDLE) begin
      w_next = IDLE;
      w_cnt  = '0;
    end
  end
  assign bus.addrWE         = r_state == GOT_ADDR;
  assign bus.srParallelLoad = r_state == READ_LOAD;
  assign bus.misoBufE       = r_state == READ_SEND;
  assign bus.dmWE           = r_state == WRITE_COMMIT;
`ifdef SPI_FSM_ABORT_CNT_EN
  logic [7:0] r_abort;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      r_abort <= '0;
    else if (bus.cs && r_state != IDLE && r_state != DONE && r_abort != 8'hFF)
      r_abort <= r_abort + 1'b1;
  assign bus.abortCnt = r_abort;
`endif
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: randomized transactions; expected output pulses are derived from strobe timestamps
// and queued, and a negedge monitor pops and compares them whenever the DUT raises any output.
module tb_spi_fsm;
  logic clk = 0, reset = 1;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_fsm_if bus();
  spi_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { int cyc; logic [3:0] v; } ev_t;
  ev_t q[$];
  int checks = 0, passed = 0;
  int a, m, ns, aborts = 0;
  logic rd = 0;
  bit in_txn = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
  endfunction

  logic [3:0] mv;
  ev_t me;
  always @(negedge clk) if (!reset) begin
    mv = {bus.addrWE, bus.srParallelLoad, bus.misoBufE, bus.dmWE};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      me = q.pop_front();
      check("missed_event", 0, int'(me.v));
    end
    if (mv != 0) begin
      check("exclusive_pulses", int'(bus.addrWE) + int'(bus.srParallelLoad) + int'(bus.dmWE) <= 1, 1);
      if (q.size() == 0) check("unexpected_output", int'(mv), 0);
      else begin
        me = q.pop_front();
        check("event_cycle", cyc, me.cyc);
        check("event_outputs", int'(mv), int'(me.v));
      end
    end
  end

  // Outputs at cycle n follow from strobe timestamps: a = 8th address strobe, m = 8th data strobe.
  task automatic step(input logic c, input logic s);
    int n;
    logic [3:0] v;
    bus.cs = c;
    bus.sclkPosEdge = s;
    bus.rwBit = rd;
    if (c) begin
      if (in_txn && ns < 16) aborts++;
      in_txn = 0;
    end else if (!in_txn) begin
      in_txn = 1; a = -1; m = -1; ns = 0;
    end else if (s && ns < 16) begin
      ns++;
      if (ns == 8) a = cyc;
      if (ns == 16) m = cyc;
    end
    n = cyc + 1;
    v = '0;
    if (in_txn) begin
      v[3] = a >= 0 && n == a + 1;
      v[2] = rd && a >= 0 && n == a + 3;
      v[1] = rd && a >= 0 && n >= a + 4 && (m < 0 || n <= m);
      v[0] = !rd && m >= 0 && n == m + 1;
    end
    if (v != 0) q.push_back('{n, v});
    @(posedge clk);
    #1;
  endtask

  task automatic check_abort_cnt();
`ifdef SPI_FSM_ABORT_CNT_EN
    check("abort_cnt", int'(bus.abortCnt), aborts > 255 ? 255 : aborts);
`endif
  endtask

  task automatic run(input logic r, input int ab_at, input bit same, input int extra);
    rd = r;
    step(0, 0);
    for (int i = 1; i <= 16; i++) begin
      repeat (4 + $urandom_range(0, 3)) step(0, 0);
      if (i == ab_at) begin
        step(1, same);
        break;
      end
      step(0, 1);
    end
    if (ab_at == 0) begin
      repeat (extra) begin
        repeat (4) step(0, 0);
        step(0, 1);
      end
      step(0, 0);
    end
    repeat (1 + $urandom_range(0, 2)) step(1, 0);
    check_abort_cnt();
  endtask

  initial begin
    bus.cs = 1; bus.sclkPosEdge = 0; bus.rwBit = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'({bus.addrWE, bus.srParallelLoad, bus.misoBufE, bus.dmWE}), 0);
    check_abort_cnt();
    reset = 0;
    step(1, 0);
    run(0, 0, 0, 0);
    run(1, 0, 0, 0);
    run(0, 4, 0, 0);
    run(0, 16, 1, 0);
    run(1, 12, 1, 0);
    run(0, 8, 1, 0);
    run(1, 0, 0, 10);
    run(0, 0, 0, 10);
    for (int t = 0; t < 30; t++)
      run(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0 ? $urandom_range(1, 16) : 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0 ? 10 : 0);
    rd = 1;
    step(0, 0);
    for (int i = 1; i <= 11; i++) begin
      repeat (5) step(0, 0);
      step(0, 1);
    end
    step(0, 0);
    check("miso_before_reset", int'(bus.misoBufE), 1);
    reset = 1;
    bus.cs = 1;
    bus.sclkPosEdge = 0;
    #1;
    check("async_reset_outputs", int'({bus.addrWE, bus.srParallelLoad, bus.misoBufE, bus.dmWE}), 0);
    q.delete();
    in_txn = 0;
    aborts = 0;
    repeat (2) @(posedge clk);
    #1;
    check_abort_cnt();
    reset = 0;
    run(0, 0, 0, 0);
    for (int i = 0; i < 260; i++) begin
      rd = 0;
      step(0, 0);
      step(1, 0);
    end
    step(1, 0);
    check_abort_cnt();
    run(1, 0, 0, 0);
    repeat (3) step(1, 0);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/spi_fsm.md
Name: spi_fsm

Overview:
- Transaction controller for the SPI peripheral; sits directly downstream of the shift register.
- Watches conditioned chip select and SCLK edge strobes, and counts serial bits. Once the address byte is in, it decodes the R/W bit from the shift register's parallel output.
- Drives the shift register parallelLoad, the address-latch write enable, the data-memory write enable and the MISO buffer enable.
- Moore machine; all outputs decode from the registered state.

Parameters:
- width, 8, bits per SPI phase (address+R/W phase and data phase); must match the shift register width.
- cntWidth, 4, bit counter width; must satisfy 2^cntWidth > width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears the counter immediately.
- cs  input  1  conditioned chip select, active-low; synchronous to clk.
- sclkPosEdge  input  1  one-clk strobe per SCLK rising edge; the shift register shifts on the same strobe.
- rwBit  input  1  shift register parallelDataOut[width-1]; 1=read, 0=write.
- srParallelLoad  output  1  to shift register parallelLoad.
- addrWE  output  1  loads the address latch from shift register parallelDataOut.
- dmWE  output  1  data memory write enable.
- misoBufE  output  1  MISO tri-state buffer enable.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, bitCnt=0.
  - All outputs 0 while reset is high and in the first cycle after release.
- Priority: cs==1 in any state other than IDLE forces next state IDLE and bitCnt=0.
  - This overrides every other transition, including entry to WRITE_COMMIT; an aborted write never asserts dmWE.
- IDLE:
  - Outputs 0, bitCnt held 0.
  - cs==0 -> GET_ADDR.
- GET_ADDR:
  - bitCnt increments on each cycle with sclkPosEdge=1.
  - On the strobe that makes bitCnt==width -> GOT_ADDR next cycle.
- GOT_ADDR (1 cycle):
  - addrWE=1; bitCnt cleared.
  - rwBit sampled this cycle, which is one clk after the last shift, so the shift register is settled.
  - rwBit=1 -> READ_WAIT; rwBit=0 -> WRITE_RECV.
- READ_WAIT (1 cycle): memory read latency; all outputs 0 -> READ_LOAD.
- READ_LOAD (1 cycle): srParallelLoad=1 -> READ_SEND.
- READ_SEND:
  - misoBufE=1.
  - Count sclkPosEdge; the strobe making bitCnt==width -> DONE.
- WRITE_RECV:
  - Count sclkPosEdge; the strobe making bitCnt==width -> WRITE_COMMIT.
- WRITE_COMMIT (1 cycle): dmWE=1 -> DONE.
- DONE:
  - Outputs 0; bitCnt=0.
  - Stay until cs==1 -> IDLE. Extra SCLK edges while cs stays low are ignored.
- Counter:
  - bitCnt is unsigned cntWidth bits and never exceeds width.
  - It is cleared on every phase transition and never wraps.
- Latency:
  - addrWE asserts exactly 1 clk after the width-th address strobe.
  - srParallelLoad asserts 3 clks after that strobe.
  - dmWE asserts 1 clk after the width-th data strobe.
- Simultaneous events: a sclkPosEdge in the same cycle as cs==1 is not counted.
- sclkPosEdge in GOT_ADDR, READ_WAIT, READ_LOAD or WRITE_COMMIT is ignored and not counted. The master must not clock during these 1-3 clk gaps; the SCLK period is well above 4 clk.
- Only one of addrWE, dmWE, srParallelLoad is ever high in a given cycle.

Optional Feature:
- Macro SPI_FSM_ABORT_CNT_EN.
- Defined:
  - Adds output abortCnt [7:0].
  - Increments by 1 on each cycle where cs==1 and the state is not IDLE or DONE.
  - Saturates at 8'hFF; cleared only by reset (asynchronous, to 0).
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Write, width=8: cs=0, shift 8'h55 with rwBit=0 at strobe 8 -> addrWE=1 for exactly 1 clk; then 8 strobes -> dmWE=1 for exactly 1 clk, 1 clk after strobe 16; state DONE; cs=1 -> IDLE.
- Read: cs=0, 8 strobes with rwBit=1 -> addrWE pulse, then srParallelLoad=1 exactly 2 clks after addrWE; misoBufE high from the next clk through the 8th data strobe, then 0 in DONE.
- Abort in address phase: cs=0, 3 strobes, cs=1 -> next clk IDLE, no addrWE/dmWE ever; with SPI_FSM_ABORT_CNT_EN, abortCnt 0->1.
- Abort on the 8th data strobe of a write (cs=1 same cycle) -> dmWE never asserts, state IDLE, bitCnt=0.
- Reset asserted mid-READ_SEND -> outputs drop to 0 asynchronously before the next clk edge; after release with cs=0, a full write completes normally.
- cs held low after DONE with 10 further strobes -> no outputs assert, state stays DONE; 256 aborts with SPI_FSM_ABORT_CNT_EN -> abortCnt=8'hFF, held.
